// File: rtl/func_pkg.sv
// ---------------------------------------------------------------------------
// func_pkg
// Shared definitions for the function-selector request path: function codes,
// operand/result widths and the request sequencer state encoding.
// ---------------------------------------------------------------------------
package func_pkg;

  localparam logic [1:0] FUNC_EXP = 2'b00;
  localparam logic [1:0] FUNC_SIN = 2'b01;
  localparam logic [1:0] FUNC_COS = 2'b10;
  localparam logic [1:0] FUNC_LN  = 2'b11;

  localparam int X_W = 16;
  localparam int R_W = 18;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/func_seq_watchdog.sv
// ---------------------------------------------------------------------------
// func_seq_watchdog
// Cycle counter that bounds the time the sequencer spends waiting on the
// selector. Only instantiated when FUNC_SEQ_TIMEOUT_EN is defined.
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset
//   clr    in   clear counter to zero (one job start)
//   en     in   count this cycle (job outstanding)
//   expire out  high during the LIMIT-th enabled cycle since clr
// ---------------------------------------------------------------------------
module func_seq_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter holds k during the (k+1)-th enabled cycle, so LIMIT-1 marks the
  // last cycle before the budget is exhausted.
  assign expire = en && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/func_request_sequencer.sv
// ---------------------------------------------------------------------------
// func_request_sequencer
// Issues one (x, func) job at a time to the function selector over its
// start/done interface and returns the result on a valid/ready channel.
// sel_x/sel_func are held from acceptance until the next accepted job, since
// the selector muxes done and result by func.
//
// Optional feature macro: FUNC_SEQ_TIMEOUT_EN
//   defined   : job aborted after TIMEOUT_CYCLES in ARM+WAIT (rsp_err=1)
//   undefined : no watchdog, rsp_err tied low, waits indefinitely
//
// state | meaning
// IDLE  | ready for a job (req_ready=1)
// ISSUE | one-cycle sel_start pulse
// ARM   | wait for stale done from a previous job to drop
// WAIT  | wait for done, capture result
// RESP  | hold response until rsp_ready
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   req_valid/req_ready/req_x/req_func job request channel
//   sel_start/sel_x/sel_func           selector drive (registered)
//   sel_rBus/sel_done                  selector result / done level
//   rsp_valid/rsp_ready                response channel
//   rsp_data/rsp_func/rsp_err          response payload (registered)
//   job_count                          completed responses, wraps
// ---------------------------------------------------------------------------
module func_request_sequencer
  import func_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [X_W-1:0]   req_x,
  input  logic [1:0]       req_func,
  output logic             sel_start,
  output logic [X_W-1:0]   sel_x,
  output logic [1:0]       sel_func,
  input  logic [R_W-1:0]   sel_rBus,
  input  logic             sel_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [R_W-1:0]   rsp_data,
  output logic [1:0]       rsp_func,
  output logic             rsp_err,
  output logic [CNT_W-1:0] job_count
);

  seq_state_e       state_q, state_d;
  logic             sel_start_q, sel_start_d;
  logic [X_W-1:0]   sel_x_q, sel_x_d;
  logic [1:0]       sel_func_q, sel_func_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [R_W-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]       rsp_func_q, rsp_func_d;
  logic [CNT_W-1:0] job_count_q, job_count_d;
  logic             timeout_hit;

`ifdef FUNC_SEQ_TIMEOUT_EN
  logic rsp_err_q, rsp_err_d;
  logic wd_clr, wd_en;

  assign wd_clr = (state_q == ISSUE);
  assign wd_en  = (state_q == ARM) || (state_q == WAIT);

  func_seq_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (timeout_hit)
  );

  // A real capture in the same cycle as expiry wins over the abort.
  always_comb begin
    rsp_err_d = rsp_err_q;
    if (state_q == IDLE && req_valid) begin
      rsp_err_d = 1'b0;
    end else if (state_q == WAIT && sel_done) begin
      rsp_err_d = 1'b0;
    end else if (timeout_hit) begin
      rsp_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sel_start_d = 1'b0;
    sel_x_d     = sel_x_q;
    sel_func_d  = sel_func_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_func_d  = rsp_func_q;
    job_count_d = job_count_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          sel_x_d     = req_x;
          sel_func_d  = req_func;
          rsp_func_d  = req_func;
          sel_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = ARM;
      end
      ARM: begin
        if (timeout_hit) begin
          rsp_data_d  = '0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (!sel_done) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (sel_done) begin
          rsp_data_d  = sel_rBus;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (timeout_hit) begin
          rsp_data_d  = '0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          job_count_d = job_count_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_start_q <= 1'b0;
      sel_x_q     <= '0;
      sel_func_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_func_q  <= '0;
      job_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_start_q <= sel_start_d;
      sel_x_q     <= sel_x_d;
      sel_func_q  <= sel_func_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_func_q  <= rsp_func_d;
      job_count_q <= job_count_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign sel_start = sel_start_q;
  assign sel_x     = sel_x_q;
  assign sel_func  = sel_func_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_func  = rsp_func_q;
  assign job_count = job_count_q;

endmodule

// File: tb/tb_func_request_sequencer.sv
// ---------------------------------------------------------------------------
// tb_func_request_sequencer
// Directed bench for func_request_sequencer with a scripted selector model.
// Build with or without FUNC_SEQ_TIMEOUT_EN; expectations follow the macro.
// ---------------------------------------------------------------------------
module tb_func_request_sequencer;
  import func_pkg::*;

  localparam int CNT_W = 4;
  localparam int TMO   = 16;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [15:0]      req_x;
  logic [1:0]       req_func;
  logic             sel_start;
  logic [15:0]      sel_x;
  logic [1:0]       sel_func;
  logic [17:0]      sel_rBus;
  logic             sel_done;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [17:0]      rsp_data;
  logic [1:0]       rsp_func;
  logic             rsp_err;
  logic [CNT_W-1:0] job_count;

  int total;
  int bad;
  int exp_cnt;

  func_request_sequencer #(
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_func  (req_func),
    .sel_start (sel_start),
    .sel_x     (sel_x),
    .sel_func  (sel_func),
    .sel_rBus  (sel_rBus),
    .sel_done  (sel_done),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_func  (rsp_func),
    .rsp_err   (rsp_err),
    .job_count (job_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a job, then script the selector: optional stale-done drop at
  // start+drop_at, done rises at start+rise_at. Returns in the first RESP cycle.
  task automatic run_job(input logic [15:0] x, input logic [1:0] f,
                         input int drop_at, input int rise_at,
                         input logic [17:0] rdata);
    chk_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_x     = x;
    req_func  = f;
    tick();
    req_valid = 1'b0;
    chk_eq("start_pulse", 32'(sel_start), 32'd1);
    chk_eq("sel_x_latch", 32'(sel_x), 32'(x));
    chk_eq("sel_func_latch", 32'(sel_func), 32'(f));
    if (drop_at == 0) sel_done = 1'b0;
    for (int k = 1; k <= rise_at; k++) begin
      tick();
      chk_eq("start_low", 32'(sel_start), 32'd0);
      chk_eq("sel_x_hold", 32'(sel_x), 32'(x));
      chk_eq("sel_func_hold", 32'(sel_func), 32'(f));
      chk_eq("no_early_rsp", 32'(rsp_valid), 32'd0);
      chk_eq("busy_not_ready", 32'(req_ready), 32'd0);
      if (k == drop_at) sel_done = 1'b0;
      if (k == rise_at) begin
        sel_done = 1'b1;
        sel_rBus = rdata;
      end
    end
    tick();
    chk_eq("rsp_valid", 32'(rsp_valid), 32'd1);
  endtask

  // Hold off rsp_ready for 'hold' cycles, then complete the handshake.
  task automatic take_rsp(input int hold, input logic [17:0] d,
                          input logic [1:0] f, input logic e);
    for (int i = 0; i < hold; i++) begin
      chk_eq("bp_valid", 32'(rsp_valid), 32'd1);
      chk_eq("bp_data", 32'(rsp_data), 32'(d));
      chk_eq("bp_not_ready", 32'(req_ready), 32'd0);
      chk_eq("bp_no_start", 32'(sel_start), 32'd0);
      tick();
    end
    chk_eq("rsp_valid_hs", 32'(rsp_valid), 32'd1);
    chk_eq("rsp_data", 32'(rsp_data), 32'(d));
    chk_eq("rsp_func", 32'(rsp_func), 32'(f));
    chk_eq("rsp_err", 32'(rsp_err), 32'(e));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    chk_eq("rsp_valid_clr", 32'(rsp_valid), 32'd0);
    chk_eq("job_count", 32'(job_count), 32'(exp_cnt));
    chk_eq("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    exp_cnt   = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_x     = '0;
    req_func  = '0;
    sel_rBus  = '0;
    sel_done  = 1'b0;
    rsp_ready = 1'b0;
    #12;
    chk_eq("rst_sel_start", 32'(sel_start), 32'd0);
    chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_eq("rst_job_count", 32'(job_count), 32'd0);
    tick();
    rst = 1'b0;
    chk_eq("rst_req_ready", 32'(req_ready), 32'd1);
    chk_eq("rst_sel_x", 32'(sel_x), 32'd0);
    chk_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    tick();

    // basic: done 7 cycles after start, left high afterwards
    run_job(16'h0100, FUNC_SIN, 0, 7, 18'h00ABC);
    take_rsp(0, 18'h00ABC, FUNC_SIN, 1'b0);

    // stale done: held from previous job, drops at +3, rises at +8
    run_job(16'h0200, FUNC_SIN, 3, 8, 18'h12345);
    take_rsp(0, 18'h12345, FUNC_SIN, 1'b0);

    // backpressure with a new job waiting
    run_job(16'h2222, FUNC_COS, 0, 4, 18'h30F0F);
    req_valid = 1'b1;
    req_x     = 16'h3333;
    req_func  = FUNC_LN;
    take_rsp(5, 18'h30F0F, FUNC_COS, 1'b0);
    run_job(16'h3333, FUNC_LN, 0, 3, 18'h05555);
    take_rsp(0, 18'h05555, FUNC_LN, 1'b0);

    // done never rises
    req_valid = 1'b1;
    req_x     = 16'h4444;
    req_func  = FUNC_EXP;
    tick();
    req_valid = 1'b0;
    sel_done  = 1'b0;
    chk_eq("tmo_start", 32'(sel_start), 32'd1);
`ifdef FUNC_SEQ_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      tick();
      chk_eq("tmo_wait", 32'(rsp_valid), 32'd0);
    end
    tick();
    take_rsp(0, 18'h00000, FUNC_EXP, 1'b1);
    req_valid = 1'b1;
    req_x     = 16'h7777;
    req_func  = FUNC_LN;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
`else
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk_eq("no_tmo_wait", 32'(rsp_valid), 32'd0);
    end
`endif

    // reset while waiting
    chk_eq("pre_rst_busy", 32'(req_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_sel_x", 32'(sel_x), 32'd0);
    chk_eq("mid_rst_sel_func", 32'(sel_func), 32'd0);
    chk_eq("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
    chk_eq("mid_rst_rsp_func", 32'(rsp_func), 32'd0);
    chk_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk_eq("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
    chk_eq("mid_rst_job_count", 32'(job_count), 32'd0);
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    chk_eq("post_rst_ready", 32'(req_ready), 32'd1);
    tick();

    // wrap: 17 jobs, all func codes
    for (int i = 0; i < 17; i++) begin
      logic [15:0] wx;
      logic [1:0]  wf;
      logic [17:0] wd;
      wx = 16'(i * 16'h0111 + 1);
      wf = 2'(i % 4);
      wd = 18'(i * 18'h00101 + 7);
      run_job(wx, wf, 0, 3, wd);
      take_rsp(0, wd, wf, 1'b0);
    end
    chk_eq("wrap_count", 32'(job_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
